// File: rtl/ccff_loader.sv
// rtl/ccff_loader.sv - word-to-serial loader for a ccff configuration chain (optional readback: CCFF_LOADER_READBACK_EN)
module ccff_loader #(
    parameter int CHAIN_LEN = 64,
    parameter int WORD_W    = 8
) (
    input  logic              prog_clk,
    input  logic              prog_reset_n,
    input  logic              start,
    input  logic [WORD_W-1:0] cfg_data,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic              ccff_head,
    output logic              ccff_shift_en,
    input  logic              ccff_tail,
    output logic              busy,
    output logic              done,
    output logic [WORD_W-1:0] rb_data,
    output logic              rb_valid
);

    localparam int CW = $clog2(CHAIN_LEN + 1);
    localparam int WB = (WORD_W > 1) ? $clog2(WORD_W) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [WORD_W-1:0] shift_reg;
    logic [CW-1:0]     bit_cnt;
    logic [WB-1:0]     word_cnt;
    logic              last_bit;
    logic              last_word;

    assign last_bit  = (bit_cnt == CW'(CHAIN_LEN - 1));
    assign last_word = (word_cnt == WB'(WORD_W - 1));

    // State register; reset aborts any load in progress immediately
    always_ff @(posedge prog_clk or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and decoded outputs; all outputs are zero in IDLE so reset clears them at once
    always_comb begin
        state_nxt     = state;
        cfg_ready     = 1'b0;
        ccff_shift_en = 1'b0;
        ccff_head     = 1'b0;
        busy          = 1'b0;
        done          = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = LOAD;
            end
            LOAD: begin
                cfg_ready = 1'b1;
                busy      = 1'b1;
                if (cfg_valid) state_nxt = SHIFT;
            end
            SHIFT: begin
                ccff_shift_en = 1'b1;
                ccff_head     = shift_reg[0];
                busy          = 1'b1;
                if (last_bit) begin
                    state_nxt = DONE;
                end else if (last_word) begin
                    state_nxt = LOAD;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) state_nxt = LOAD;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: word capture, serialisation and bit/word position counters
    always_ff @(posedge prog_clk or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
            word_cnt  <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        bit_cnt  <= '0;
                        word_cnt <= '0;
                    end
                end
                LOAD: begin
                    word_cnt <= '0;
                    if (cfg_valid) shift_reg <= cfg_data;
                end
                SHIFT: begin
                    shift_reg <= shift_reg >> 1;
                    bit_cnt   <= bit_cnt + CW'(1);
                    word_cnt  <= last_word ? '0 : word_cnt + WB'(1);
                end
                default: ;
            endcase
        end
    end

`ifdef CCFF_LOADER_READBACK_EN
    logic [WORD_W-1:0] rb_acc;
    logic [WORD_W-1:0] rb_next;

    // Tail sample lands at the same bit position its loaded counterpart had
    assign rb_next = rb_acc | (WORD_W'(ccff_tail) << word_cnt);

    // Readback accumulator; publishes a full word, or a zero-filled partial word at chain end
    always_ff @(posedge prog_clk or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            rb_acc   <= '0;
            rb_data  <= '0;
            rb_valid <= 1'b0;
        end else begin
            rb_valid <= 1'b0;
            if (state == SHIFT) begin
                if (last_bit || last_word) begin
                    rb_data  <= rb_next;
                    rb_valid <= 1'b1;
                    rb_acc   <= '0;
                end else begin
                    rb_acc <= rb_next;
                end
            end
        end
    end
`else
    logic unused_tail;

    assign unused_tail = ccff_tail;
    assign rb_data     = '0;
    assign rb_valid    = 1'b0;
`endif

endmodule

// File: tb/tb_ccff_loader.sv
// tb/tb_ccff_loader.sv - self-checking bench for ccff_loader (64-bit and 12-bit chains)
module tb_ccff_loader;

    logic       prog_clk = 1'b0;
    logic       prog_reset_n = 1'b0;
    logic       start_a = 1'b0;
    logic       start_b = 1'b0;
    logic [7:0] cfg_data = 8'h00;
    logic       cfg_valid = 1'b0;

    logic       ready_a, head_a, sen_a, tail_a, busy_a, done_a, rb_valid_a;
    logic [7:0] rb_data_a;
    logic       ready_b, head_b, sen_b, tail_b, busy_b, done_b, rb_valid_b;
    logic [7:0] rb_data_b;

    logic [63:0] chain_a = '0;
    logic [11:0] chain_b = '0;
    logic        preload = 1'b0;
    int          sh_a = 0;
    int          sh_b = 0;
    int          cyc = 0;
    logic [7:0]  rb_q [$];
    int          rb_b_cnt = 0;

    logic [7:0]  wq [$];
    int          base;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [63:0] ref_chain;

    ccff_loader #(.CHAIN_LEN(64), .WORD_W(8)) dut (
        .prog_clk(prog_clk), .prog_reset_n(prog_reset_n), .start(start_a),
        .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_ready(ready_a),
        .ccff_head(head_a), .ccff_shift_en(sen_a), .ccff_tail(tail_a),
        .busy(busy_a), .done(done_a), .rb_data(rb_data_a), .rb_valid(rb_valid_a)
    );

    ccff_loader #(.CHAIN_LEN(12), .WORD_W(8)) dut12 (
        .prog_clk(prog_clk), .prog_reset_n(prog_reset_n), .start(start_b),
        .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_ready(ready_b),
        .ccff_head(head_b), .ccff_shift_en(sen_b), .ccff_tail(tail_b),
        .busy(busy_b), .done(done_b), .rb_data(rb_data_b), .rb_valid(rb_valid_b)
    );

    always #5 prog_clk = ~prog_clk;

    assign tail_a = chain_a[63];
    assign tail_b = chain_b[11];

    // Behavioural chains: first bit shifted in ends up at the tail
    always @(posedge prog_clk) begin
        if (preload) chain_a <= '1;
        else if (sen_a) chain_a <= {chain_a[62:0], head_a};
        if (sen_b) chain_b <= {chain_b[10:0], head_b};
        if (sen_a) sh_a <= sh_a + 1;
        if (sen_b) sh_b <= sh_b + 1;
        cyc <= cyc + 1;
    end

    // Readback strobe collection
    always @(negedge prog_clk) begin
        if (rb_valid_a) rb_q.push_back(rb_data_a);
        if (rb_valid_b) rb_b_cnt = rb_b_cnt + 1;
    end

    function automatic logic rdy(input bit sel);
        return sel ? ready_b : ready_a;
    endfunction

    function automatic logic is_done(input bit sel);
        return sel ? done_b : done_a;
    endfunction

    // Expected 64-bit chain: stream bit i = word[i/8] bit i%8, stream bit 0 at the tail
    function automatic logic [63:0] exp_chain64();
        logic [63:0] e;
        logic [7:0]  w;
        for (int i = 0; i < 64; i++) begin
            w = wq[i / 8];
            e[63 - i] = w[i % 8];
        end
        return e;
    endfunction

    task automatic run_load(input bit sel, input int stall, input bit poke_start, output int lat);
        int c0;
        int g;
        @(negedge prog_clk);
        if (sel) start_b = 1'b1; else start_a = 1'b1;
        @(negedge prog_clk);
        start_a = 1'b0;
        start_b = 1'b0;
        c0 = cyc;
        base = sel ? sh_b : sh_a;
        for (int k = 0; k < wq.size(); k++) begin
            if (stall > 0 && k > 0) begin
                cfg_valid = 1'b0;
                g = 0;
                while (!rdy(sel) && g < 100) begin @(negedge prog_clk); g++; end
                for (int s = 0; s < stall; s++) begin
                    n_cmp++;
                    if ({rdy(sel), sel ? sen_b : sen_a} !== 2'b10) begin
                        n_bad++;
                        $display("FAIL stall_hold: ready/shift_en=%b required 10", {rdy(sel), sel ? sen_b : sen_a});
                    end
                    @(negedge prog_clk);
                end
            end
            cfg_data = wq[k];
            cfg_valid = 1'b1;
            g = 0;
            while (!rdy(sel) && g < 100) begin @(negedge prog_clk); g++; end
            if (g >= 100) begin
                n_cmp++; n_bad++;
                $display("FAIL ready_timeout: word %0d never accepted", k);
            end
            @(negedge prog_clk);
            if (poke_start && k == 2) begin
                n_cmp++;
                if (busy_a !== 1'b1) begin
                    n_bad++;
                    $display("FAIL busy_during_shift: busy=%b required 1", busy_a);
                end
                start_a = 1'b1;
                @(negedge prog_clk);
                start_a = 1'b0;
            end
        end
        cfg_valid = 1'b0;
        g = 0;
        while (!is_done(sel) && g < 300) begin @(negedge prog_clk); g++; end
        n_cmp++;
        if (g >= 300) begin
            n_bad++;
            $display("FAIL done_timeout: done never rose");
        end
        lat = cyc - c0;
    endtask

    task automatic check_load64(input string nm, input int exp_lat, input int lat);
        n_cmp++;
        if (lat !== exp_lat) begin
            n_bad++;
            $display("FAIL %s_latency: got %0d required %0d", nm, lat, exp_lat);
        end
        n_cmp++;
        if (sh_a - base !== 64) begin
            n_bad++;
            $display("FAIL %s_shift_count: got %0d required 64", nm, sh_a - base);
        end
        n_cmp++;
        if (chain_a !== exp_chain64()) begin
            n_bad++;
            $display("FAIL %s_chain: got %h required %h", nm, chain_a, exp_chain64());
        end
        n_cmp++;
        if ({done_a, busy_a, ready_a, sen_a, head_a} !== 5'b10000) begin
            n_bad++;
            $display("FAIL %s_done_outputs: got %b required 10000", nm, {done_a, busy_a, ready_a, sen_a, head_a});
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge prog_clk);
        n_cmp++;
        if ({ready_a, head_a, sen_a, busy_a, done_a, rb_valid_a, rb_data_a,
             ready_b, head_b, sen_b, busy_b, done_b, rb_valid_b, rb_data_b} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: some output nonzero during reset (a rdy=%b busy=%b done=%b)", ready_a, busy_a, done_a);
        end
        prog_reset_n = 1'b1;
        repeat (2) @(negedge prog_clk);
        n_cmp++;
        if ({ready_a, sen_a, busy_a, done_a} !== 4'b0000) begin
            n_bad++;
            $display("FAIL idle_outputs: got %b required 0000", {ready_a, sen_a, busy_a, done_a});
        end
    endtask

    task automatic test_basic();
        int lat;
        wq = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        run_load(0, 0, 0, lat);
        check_load64("basic", 72, lat);
        ref_chain = chain_a;
    endtask

    task automatic test_chain12();
        int lat;
        wq = '{8'hA5, 8'h3C};
        run_load(1, 0, 0, lat);
        n_cmp++;
        if (sh_b - base !== 12) begin
            n_bad++;
            $display("FAIL c12_shift_count: got %0d required 12", sh_b - base);
        end
        n_cmp++;
        if (chain_b !== 12'b1010_0101_0011) begin
            n_bad++;
            $display("FAIL c12_bits: got %b required 101001010011", chain_b);
        end
        n_cmp++;
        if ({done_b, busy_b} !== 2'b10) begin
            n_bad++;
            $display("FAIL c12_done: done/busy=%b required 10", {done_b, busy_b});
        end
    endtask

    task automatic test_stall();
        int lat;
        wq = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        run_load(0, 5, 0, lat);
        check_load64("stall", 72 + 7 * 5, lat);
        n_cmp++;
        if (chain_a !== ref_chain) begin
            n_bad++;
            $display("FAIL stall_vs_nostall: got %h required %h", chain_a, ref_chain);
        end
    endtask

    task automatic test_random();
        int lat;
        int st;
        for (int it = 0; it < 4; it++) begin
            wq.delete();
            for (int k = 0; k < 8; k++) wq.push_back(8'($urandom));
            st = $urandom_range(0, 3);
            run_load(0, st, 0, lat);
            check_load64("random", 72 + 7 * st, lat);
        end
    endtask

    task automatic test_reset_mid();
        int g;
        int n;
        int lat;
        @(negedge prog_clk);
        start_a = 1'b1;
        @(negedge prog_clk);
        start_a = 1'b0;
        base = sh_a;
        cfg_data = 8'($urandom);
        cfg_valid = 1'b1;
        g = 0;
        while (sh_a - base < 20 && g < 200) begin @(negedge prog_clk); g++; end
        prog_reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({ready_a, head_a, sen_a, busy_a, done_a, rb_valid_a, rb_data_a} !== '0) begin
            n_bad++;
            $display("FAIL reset_mid_outputs: rdy=%b head=%b sen=%b busy=%b done=%b", ready_a, head_a, sen_a, busy_a, done_a);
        end
        cfg_valid = 1'b0;
        n = sh_a;
        repeat (3) @(negedge prog_clk);
        n_cmp++;
        if (sh_a !== n) begin
            n_bad++;
            $display("FAIL reset_mid_no_shift: got %0d extra shifts required 0", sh_a - n);
        end
        prog_reset_n = 1'b1;
        wq.delete();
        for (int k = 0; k < 8; k++) wq.push_back(8'($urandom));
        run_load(0, 0, 0, lat);
        check_load64("reset_reload", 72, lat);
    endtask

    task automatic test_start_busy();
        int lat;
        wq.delete();
        for (int k = 0; k < 8; k++) wq.push_back(8'($urandom));
        run_load(0, 0, 1, lat);
        check_load64("start_busy", 72, lat);
        @(negedge prog_clk);
        start_a = 1'b1;
        @(negedge prog_clk);
        start_a = 1'b0;
        n_cmp++;
        if ({done_a, busy_a, ready_a} !== 3'b011) begin
            n_bad++;
            $display("FAIL restart_from_done: done/busy/ready=%b required 011", {done_a, busy_a, ready_a});
        end
        prog_reset_n = 1'b0;
        @(negedge prog_clk);
        prog_reset_n = 1'b1;
        @(negedge prog_clk);
    endtask

    task automatic test_readback();
        int lat;
        int n0;
`ifdef CCFF_LOADER_READBACK_EN
        @(negedge prog_clk);
        preload = 1'b1;
        @(negedge prog_clk);
        preload = 1'b0;
        wq = '{8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'h5A};
        run_load(0, 0, 0, lat);
        repeat (2) @(negedge prog_clk);
        n0 = rb_q.size();
        run_load(0, 0, 0, lat);
        repeat (2) @(negedge prog_clk);
        n_cmp++;
        if (rb_q.size() - n0 !== 8) begin
            n_bad++;
            $display("FAIL rb_strobes: got %0d required 8", rb_q.size() - n0);
        end
        for (int i = n0; i < rb_q.size(); i++) begin
            n_cmp++;
            if (rb_q[i] !== 8'h5A) begin
                n_bad++;
                $display("FAIL rb_data_%0d: got %h required 5a", i - n0, rb_q[i]);
            end
        end
`else
        wq = '{8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'h5A};
        run_load(0, 0, 0, lat);
        repeat (2) @(negedge prog_clk);
        n0 = rb_q.size() + rb_b_cnt;
        n_cmp++;
        if (n0 !== 0) begin
            n_bad++;
            $display("FAIL rb_absent_strobes: got %0d required 0", n0);
        end
        n_cmp++;
        if ({rb_data_a, rb_data_b} !== 16'h0000) begin
            n_bad++;
            $display("FAIL rb_absent_data: got %h required 0000", {rb_data_a, rb_data_b});
        end
`endif
    endtask

    initial begin
        test_reset();
        test_basic();
        test_chain12();
        test_stall();
        test_random();
        test_reset_mid();
        test_start_busy();
        test_readback();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
